// File: rtl/aoi_bist_checker.sv
// Built-in self-test sequencer for a 4-input AND-OR-INVERT gate.
// Walks all 16 input vectors {a,b,c,d}, holds each one for SETTLE_CYCLES
// cycles, then compares the DUT response against ~((a&b)|(c&d)). It counts
// mismatches and captures the first failing vector. Results stay frozen in
// DONE until the next start or reset.
`timescale 1ns/1ps

module aoi_bist_checker #(
    parameter int SETTLE_CYCLES = 4        // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic [3:0] vec_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_err_vec,
    output logic       first_err_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Last settle count value; APPLY leaves on the cycle the counter shows it.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] VEC_LAST    = 4'd15;
    localparam logic [4:0] ERR_MAX     = 5'd31;

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;

    // Per-cycle control strobes produced by the FSM decode.
    logic run_clear;      // start accepted: wipe vector, counter and results
    logic cnt_inc;        // settle counter advances
    logic cnt_clear;      // settle counter returns to zero
    logic sample_commit;  // SAMPLE compare result is written to the results
    logic vec_inc;        // step to the next vector
    logic vec_clear;      // abort: vector returns to zero

    logic exp_out;
    logic mismatch;

    // Saturating increment so the error counter sticks at its maximum.
    function automatic logic [4:0] sat_inc(input logic [4:0] value);
        logic [4:0] result;
        if (value == ERR_MAX) begin
            result = value;
        end else begin
            result = value + 5'd1;
        end
        return result;
    endfunction

    // Golden AOI response is taken from the registered stimulus, so it lines
    // up with what the DUT has been seeing for the whole settle window.
    assign exp_out  = ~((vec_out[3] & vec_out[2]) | (vec_out[1] & vec_out[0]));
    assign mismatch = (dut_out != exp_out);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, datapath strobes and status outputs.
    always_comb begin
        state_next    = state;
        run_clear     = 1'b0;
        cnt_inc       = 1'b0;
        cnt_clear     = 1'b0;
        sample_commit = 1'b0;
        vec_inc       = 1'b0;
        vec_clear     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state)
            IDLE: begin
                // abort has no meaning here; only start is looked at.
                if (start) begin
                    state_next = APPLY;
                    run_clear  = 1'b1;
                end
            end

            APPLY: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                    vec_clear  = 1'b1;
                    cnt_clear  = 1'b1;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                    cnt_clear  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            SAMPLE: begin
                busy = 1'b1;
                // abort wins: the compare from this cycle is thrown away.
                if (abort) begin
                    state_next = IDLE;
                    vec_clear  = 1'b1;
                    cnt_clear  = 1'b1;
                end else begin
                    sample_commit = 1'b1;
                    if (vec_out == VEC_LAST) begin
                        state_next = DONE;
                    end else begin
                        state_next = APPLY;
                        vec_inc    = 1'b1;
                    end
                end
            end

            DONE: begin
                done = 1'b1;
                // start beats a simultaneous abort, which is ignored here anyway.
                if (start) begin
                    state_next = APPLY;
                    run_clear  = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pass = done && (err_count == 5'd0);

    // Stimulus vector and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out    <= 4'd0;
            settle_cnt <= 4'd0;
        end else begin
            if (run_clear || cnt_clear) begin
                settle_cnt <= 4'd0;
            end else if (cnt_inc) begin
                settle_cnt <= settle_cnt + 4'd1;
            end

            // vec_out only moves on SAMPLE->APPLY, keeping each vector stable
            // for SETTLE_CYCLES+1 cycles.
            if (run_clear || vec_clear) begin
                vec_out <= 4'd0;
            end else if (vec_inc) begin
                vec_out <= vec_out + 4'd1;
            end
        end
    end

    // Result registers: error count and first failing vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count       <= 5'd0;
            first_err_vec   <= 4'd0;
            first_err_valid <= 1'b0;
        end else if (run_clear) begin
            err_count       <= 5'd0;
            first_err_vec   <= 4'd0;
            first_err_valid <= 1'b0;
        end else if (sample_commit && mismatch) begin
            err_count <= sat_inc(err_count);
            if (!first_err_valid) begin
                first_err_vec   <= vec_out;
                first_err_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aoi_bist_checker.sv
// Directed bench for aoi_bist_checker: models the AOI under test in several
// fault modes and checks run latency, results, abort and reset behaviour.
`timescale 1ns/1ps

module tb_aoi_bist_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dut_out;
    logic [3:0] vec_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_err_vec;
    logic       first_err_valid;

    // 0: correct AOI, 1: stuck at 1, 2: stuck at 0, 3: inverted AOI
    int mode = 0;

    int n_checks = 0;
    int n_fail   = 0;

    aoi_bist_checker #(.SETTLE_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .dut_out         (dut_out),
        .vec_out         (vec_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid)
    );

    always #5 clk = ~clk;

    // Model of the gate under test, with optional injected faults.
    always_comb begin
        logic good;
        good = ~((vec_out[3] & vec_out[2]) | (vec_out[1] & vec_out[0]));
        case (mode)
            0:       dut_out = good;
            1:       dut_out = 1'b1;
            2:       dut_out = 1'b0;
            default: dut_out = ~good;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({vec_out, busy, done, pass, err_count, first_err_vec, first_err_valid}), 32'd0);
    endtask

    // Pulse start, then count edges until done; also verifies each vector is
    // held for exactly 5 cycles.
    task automatic run_to_done(input string tag);
        int         n;
        int         hold;
        bit         hold_bad;
        logic [3:0] pv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_nopass"}, 32'({busy, pass, done}), 32'b100);
        n        = 0;
        hold     = 1;
        hold_bad = 1'b0;
        pv       = vec_out;
        while (!done && n < 200) begin
            tick();
            n++;
            if (vec_out != pv) begin
                if (hold != 5) hold_bad = 1'b1;
                pv   = vec_out;
                hold = 1;
            end else begin
                hold++;
            end
        end
        check({tag, "_latency"}, 32'(n), 32'd80);
        check({tag, "_vec_hold"}, 32'(hold_bad), 32'd0);
    endtask

    task automatic wait_vec(input string tag, input logic [3:0] v);
        int n;
        n = 0;
        while (vec_out !== v && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, 32'(vec_out), 32'(v));
    endtask

    initial begin
        // Reset state before any clock edge.
        #3;
        check_all_zero("reset_outputs");
        tick();
        rst_n = 1'b1;

        // Correct AOI; the first start is on the first edge after reset release.
        mode = 0;
        run_to_done("good");
        check("good_pass", 32'(pass), 32'd1);
        check("good_err", 32'(err_count), 32'd0);
        check("good_fvalid", 32'(first_err_valid), 32'd0);

        // DONE holds results; abort is ignored in DONE.
        abort = 1'b1;
        repeat (10) tick();
        abort = 1'b0;
        check("done_hold", 32'({done, pass, busy, vec_out, err_count}), 32'({1'b1, 1'b1, 1'b0, 4'd15, 5'd0}));

        // Stuck at 1: mismatches at 3,7,11,12,13,14,15.
        mode = 1;
        run_to_done("stuck1");
        check("stuck1_err", 32'(err_count), 32'd7);
        check("stuck1_fvec", 32'({first_err_valid, first_err_vec}), 32'({1'b1, 4'd3}));
        check("stuck1_pass", 32'(pass), 32'd0);

        // Stuck at 0: mismatches on the 9 vectors whose expected value is 1.
        mode = 2;
        run_to_done("stuck0");
        check("stuck0_err", 32'(err_count), 32'd9);
        check("stuck0_fvec", 32'({first_err_valid, first_err_vec}), 32'({1'b1, 4'd0}));
        check("stuck0_pass", 32'(pass), 32'd0);

        // Inverted AOI: every vector fails.
        mode = 3;
        run_to_done("invert");
        check("invert_err", 32'(err_count), 32'd16);
        check("invert_fvec", 32'({first_err_valid, first_err_vec}), 32'({1'b1, 4'd0}));

        // start and abort together in DONE: start wins, results clear.
        mode  = 1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("done_start_abort", 32'({busy, done, vec_out, err_count, first_err_valid}), 32'({1'b1, 1'b0, 4'd0, 5'd0, 1'b0}));

        // start while busy must not restart the run.
        wait_vec("busy_start", 4'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_ignored", 32'({busy, vec_out}), 32'({1'b1, 4'd2}));

        // Abort during APPLY of vector 5: partial results kept (vector 3 failed).
        wait_vec("abort_apply", 4'd5);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 32'({busy, done, pass, vec_out}), 32'd0);
        check("abort_partial", 32'({err_count, first_err_valid, first_err_vec}), 32'({5'd1, 1'b1, 4'd3}));
        repeat (100) tick();
        check("abort_stays_idle", 32'({busy, done}), 32'd0);

        // Abort in the SAMPLE cycle of vector 3 discards that compare.
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec("abort_sample", 4'd3);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_sample_discard", 32'({busy, err_count, first_err_valid}), 32'd0);

        // Asynchronous reset mid-cycle during vector 9.
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vec("reset_run", 4'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        #2;
        rst_n = 1'b1;

        // Clean full run after reset.
        mode = 0;
        run_to_done("post_reset");
        check("post_reset_result", 32'({pass, err_count, first_err_valid}), 32'({1'b1, 5'd0, 1'b0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aoi_bist_checker.md
AOI_BIST_CHECKER -- requirements
Module: aoi_bist_checker

Interface
REQ-001 SETTLE_CYCLES, default 4, cycles each vector is held before sampling; the legal range is 1..15.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle run request; it is sampled only in IDLE and DONE.
REQ-005 abort  input  1  synchronous run cancel; it is honoured in APPLY and SAMPLE.
REQ-006 dut_out  input  1  response of the 4-input AOI under test.
REQ-007 vec_out  output  4  stimulus {a,b,c,d}, where a is the MSB, driven to the DUT.
REQ-008 busy  output  1  high in APPLY and SAMPLE.
REQ-009 done  output  1  high in DONE.
REQ-010 pass  output  1  high in DONE when err_count==0, otherwise 0.
REQ-011 err_count  output  5  number of mismatching vectors in the current or last run.
REQ-012 first_err_vec  output  4  the vector of the first mismatch.
REQ-013 first_err_valid  output  1  high once first_err_vec holds a mismatch from the current or last run.

Function
REQ-014 The golden model SHALL be exp = ~((a&b)|(c&d)), evaluated on the vec_out register.
REQ-015 The FSM SHALL have exactly four states: IDLE, APPLY, SAMPLE and DONE.
REQ-016 IDLE/DONE with start=1: next state APPLY; vec_out, settle counter, err_count, first_err_vec and first_err_valid all clear to 0.
REQ-017 APPLY: the settle counter increments each cycle; on the cycle where it equals SETTLE_CYCLES-1, next state SAMPLE and the counter clears.
REQ-018 SAMPLE lasts one cycle and compares dut_out with exp.
- On a mismatch, err_count increments.
- On a mismatch with first_err_valid=0, first_err_vec<=vec_out and first_err_valid<=1.
REQ-019 SAMPLE with vec_out<15: vec_out increments and next state is APPLY.
REQ-020 SAMPLE with vec_out==15: next state is DONE and vec_out holds 15.
REQ-021 vec_out SHALL change only on the SAMPLE->APPLY transition, so every vector is stable for SETTLE_CYCLES+1 cycles.
REQ-022 err_count SHALL saturate at 31, although a single run produces at most 16.
REQ-023 DONE SHALL hold all results until start or reset.
REQ-024 Latency: done SHALL rise exactly 16*(SETTLE_CYCLES+1) cycles after the edge that samples start, which is 80 cycles at the default.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 abort=1 in APPLY or SAMPLE: next state is IDLE and vec_out clears to 0.
- err_count, first_err_vec and first_err_valid keep their partial values.
- done is not asserted.
REQ-027 abort SHALL take priority over a simultaneous SAMPLE update, so the final comparison of an aborted cycle is discarded.
REQ-028 abort SHALL be ignored in IDLE and DONE.
REQ-029 start and abort high together in DONE: start wins and a new run begins.
REQ-030 pass SHALL be 0 in every state other than DONE.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE.
REQ-032 rst_n=0 SHALL immediately clear vec_out, the settle counter, err_count, first_err_vec, first_err_valid, busy, done and pass to 0.
REQ-033 Reset asserted mid-run SHALL discard the run, and no result SHALL survive it.
REQ-034 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Correct AOI connected, SETTLE_CYCLES=4, start pulse -> done rises 80 cycles after the start edge; pass=1, err_count=0, first_err_valid=0.
REQ-036 dut_out stuck at 1 -> err_count=7 (vectors 3,7,11,12,13,14,15), first_err_vec=3, pass=0.
REQ-037 dut_out stuck at 0 -> err_count=9, first_err_vec=0, pass=0.
REQ-038 dut_out = exp inverted -> err_count=16, first_err_vec=0.
REQ-039 Start pulse while busy; then abort during APPLY of vector 5 -> the start has no effect; after the abort, state=IDLE, vec_out=0, done=0 for good.
REQ-040 rst_n pulsed low between clock edges during vector 9 -> all outputs 0 immediately; a subsequent start runs a full, clean 80-cycle pass.
